// File: rtl/ice40_spram_ctrl_if.sv
// Request/response bundle between a memory client and ice40_spram_ctrl.
// Master drives req_valid/req_we/req_addr/req_wdata/req_be.
// Slave drives req_ready/rsp_valid/rsp_rdata/init_done.
`timescale 1ns/1ps
interface ice40_spram_ctrl_if #(
   parameter int AW = 16
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic [1:0]    req_be;
   logic          rsp_valid;
   logic [15:0]   rsp_rdata;
   logic          init_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
endinterface

// File: rtl/ice40_spram_ctrl.sv
// Controller over 1..4 16Kx16 SPRAM banks forming one linear 16-bit memory, with optional clear after reset.
// Read latency 1 + OUT_REG cycles from accept to rsp_valid; writes produce no response.
// req_ready is low while clearing and high in RUN; the response channel has no backpressure.
// Ports: clock_i, reset_n_i (async active-low), bus_if (slave side of ice40_spram_ctrl_if).
`timescale 1ns/1ps
module ice40_spram_ctrl #(
   parameter int BANKS          = 4,
   parameter int CLEAR_ON_RESET = 1,
   parameter int OUT_REG        = 1
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   ice40_spram_ctrl_if.slave    bus_if
);
   localparam int AW = 14 + $clog2(BANKS);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [13:0] clr_cnt_q, clr_cnt_d;
   logic        init_done_q, init_done_d;

   logic [1:0]       bank_idx;
   logic             bank_ok;
   logic             xfer;
   logic [BANKS-1:0] bank_cs;
   logic [BANKS-1:0] bank_wren;
   logic [13:0]      mem_addr;
   logic [15:0]      mem_din;
   logic [3:0]       mem_mask;
   logic [15:0]      bank_dout [BANKS];

   logic        rd_vld_q, rd_vld_d;
   logic [1:0]  rd_bank_q, rd_bank_d;
   logic        rd_ok_q, rd_ok_d;
   logic [15:0] rd_mux;
   logic        rsp_vld_q;
   logic [15:0] rsp_dat_q, rsp_dat_d;

   // Bank index from the upper address bits; a single bank has none.
   if (BANKS > 1) begin : g_multi
      assign bank_idx = 2'(bus_if.req_addr[AW-1:14]);
   end else begin : g_single
      assign bank_idx = 2'b00;
   end

   // Only matters for non-power-of-2 BANKS, where the top index values have no macro.
   assign bank_ok = (int'(bank_idx) < BANKS);
   assign xfer    = bus_if.req_valid && init_done_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == 14'h3FFF) state_d = ST_RUN;
            else                       clr_cnt_d = clr_cnt_q + 14'd1;
         end
         ST_RUN: state_d = ST_RUN;
      endcase
      // Rises on the edge that enters (or first sees) RUN, and stays high until reset.
      init_done_d = init_done_q | (state_d == ST_RUN);
   end

   // ---------------- FSM: outputs (bank controls) ----------------
   always_comb begin
      bank_cs   = '0;
      bank_wren = '0;
      mem_addr  = bus_if.req_addr[13:0];
      mem_din   = bus_if.req_wdata;
      mem_mask  = {bus_if.req_be[1], bus_if.req_be[1], bus_if.req_be[0], bus_if.req_be[0]};
      if (state_q == ST_CLEAR) begin
         // All banks share the counter address, so the clear costs one pass of 16K words.
         bank_cs   = '1;
         bank_wren = '1;
         mem_addr  = clr_cnt_q;
         mem_din   = 16'h0000;
         mem_mask  = 4'hF;
      end else if (xfer && bank_ok) begin
         for (int b = 0; b < BANKS; b++) begin
            if (bank_idx == 2'(b)) begin
               bank_cs[b]   = 1'b1;
               bank_wren[b] = bus_if.req_we;
            end
         end
      end
   end

   assign bus_if.req_ready = init_done_q;
   assign bus_if.init_done = init_done_q;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      ice40_spram_ctrl_bank u_bank (
         .clk_i      (clock_i),
         .addr_i     (mem_addr),
         .din_i      (mem_din),
         .mask_i     (mem_mask),
         .wren_i     (bank_wren[b]),
         .cs_i       (bank_cs[b]),
         .standby_i  (1'b0),
         .sleep_i    (1'b0),
         .poweroff_i (1'b1),
         .dout_o     (bank_dout[b])
      );
   end

   // ---------------- read pipeline ----------------
   // Bank index and range flag travel with the read so the mux never looks at the live address.
   always_comb begin
      rd_vld_d  = xfer && !bus_if.req_we;
      rd_bank_d = rd_vld_d ? bank_idx : rd_bank_q;
      rd_ok_d   = rd_vld_d ? bank_ok  : rd_ok_q;
   end

   always_comb begin
      rd_mux = 16'h0000;
      for (int b = 0; b < BANKS; b++) begin
         if (rd_ok_q && (rd_bank_q == 2'(b))) rd_mux = bank_dout[b];
      end
      rsp_dat_d = rd_vld_q ? rd_mux : rsp_dat_q;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_vld_q  <= 1'b0;
         rd_bank_q <= 2'b00;
         rd_ok_q   <= 1'b0;
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= 16'h0000;
      end else begin
         rd_vld_q  <= rd_vld_d;
         rd_bank_q <= rd_bank_d;
         rd_ok_q   <= rd_ok_d;
         rsp_vld_q <= rd_vld_q;
         rsp_dat_q <= rsp_dat_d;
      end
   end

   // Without the output register, rsp_dat_q only holds the last result so rsp_rdata
   // stays stable between strobes even if the macro output moves.
   if (OUT_REG != 0) begin : g_oreg
      assign bus_if.rsp_valid = rsp_vld_q;
      assign bus_if.rsp_rdata = rsp_dat_q;
   end else begin : g_noreg
      assign bus_if.rsp_valid = rd_vld_q;
      assign bus_if.rsp_rdata = rd_vld_q ? rd_mux : rsp_dat_q;
   end
endmodule

// Behavioural equivalent of one SB_SPRAM256KA (16K x 16, nibble write mask, registered read).
// Read data appears after the edge that samples the address; writes leave dout_o unchanged.
// Ports mirror the macro: ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF, DATAOUT.
module ice40_spram_ctrl_bank (
   input  logic        clk_i,
   input  logic [13:0] addr_i,
   input  logic [15:0] din_i,
   input  logic [3:0]  mask_i,
   input  logic        wren_i,
   input  logic        cs_i,
   input  logic        standby_i,
   input  logic        sleep_i,
   input  logic        poweroff_i,
   output logic [15:0] dout_o
);
   logic [15:0] mem_q [16384];
   logic [15:0] dout_q;
   logic        en;

   // POWEROFF is active-low on the macro: 1 means powered.
   assign en = cs_i && !standby_i && !sleep_i && poweroff_i;

   // The array has no reset, matching the macro.
   always_ff @(posedge clk_i) begin
      if (en) begin
         if (wren_i) begin
            for (int n = 0; n < 4; n++) begin
               if (mask_i[n]) mem_q[addr_i][4*n +: 4] <= din_i[4*n +: 4];
            end
         end else begin
            dout_q <= mem_q[addr_i];
         end
      end
   end

   assign dout_o = dout_q;
endmodule

// File: tb/tb_ice40_spram_ctrl.sv
`timescale 1ns/1ps
module tb_ice40_spram_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut4: BANKS=4, clear on reset, output register (latency 2)
   // dut3: BANKS=3, no clear, no output register (latency 1)
   ice40_spram_ctrl_if #(.AW(16)) if4 ();
   ice40_spram_ctrl_if #(.AW(16)) if3 ();

   ice40_spram_ctrl #(.BANKS(4), .CLEAR_ON_RESET(1), .OUT_REG(1)) dut4 (
      .clock_i(clk), .reset_n_i(rst_n), .bus_if(if4));
   ice40_spram_ctrl #(.BANKS(3), .CLEAR_ON_RESET(0), .OUT_REG(0)) dut3 (
      .clock_i(clk), .reset_n_i(rst_n), .bus_if(if3));

   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [15:0] req_addr  = 16'h0;
   logic [15:0] req_wdata = 16'h0;
   logic [1:0]  req_be    = 2'b00;
   int          sel       = 0;

   assign if4.req_valid = req_valid && (sel == 0);
   assign if3.req_valid = req_valid && (sel == 1);
   assign if4.req_we    = req_we;
   assign if3.req_we    = req_we;
   assign if4.req_addr  = req_addr;
   assign if3.req_addr  = req_addr;
   assign if4.req_wdata = req_wdata;
   assign if3.req_wdata = req_wdata;
   assign if4.req_be    = req_be;
   assign if3.req_be    = req_be;

   logic        o_ready, o_rsp_valid, o_init_done;
   logic [15:0] o_rsp_rdata;
   assign o_ready     = (sel == 1) ? if3.req_ready : if4.req_ready;
   assign o_rsp_valid = (sel == 1) ? if3.rsp_valid : if4.rsp_valid;
   assign o_rsp_rdata = (sel == 1) ? if3.rsp_rdata : if4.rsp_rdata;
   assign o_init_done = (sel == 1) ? if3.init_done : if4.init_done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [15:0] rsp_dq [$];
   int          rsp_cq [$];
   int          req_cq [$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_rsp_valid) begin
         rsp_dq.push_back(o_rsp_rdata);
         rsp_cq.push_back(cyc);
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All request tasks start and end at posedge+1.
   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      req_cq.push_back(cyc);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [15:0] exp_d);
      int          lat;
      int          waited;
      int          c;
      int          r;
      logic [15:0] d;
      lat    = (sel == 1) ? 1 : 2;
      waited = 0;
      while (rsp_dq.size() == 0 && waited < 8) begin
         @(posedge clk); #1;
         waited++;
      end
      if (rsp_dq.size() == 0) begin
         chk_eq({tag, "_rsp_count"}, rsp_dq.size(), 1);
         if (req_cq.size() != 0) void'(req_cq.pop_front());
      end else begin
         d = rsp_dq.pop_front();
         c = rsp_cq.pop_front();
         r = (req_cq.size() != 0) ? req_cq.pop_front() : -100;
         chk_eq({tag, "_data"}, d, exp_d);
         chk_eq({tag, "_lat"}, c - r, lat);
      end
   endtask

   task automatic count_clear(input string tag);
      int n;
      n = 0;
      while (!if4.req_ready && n < 20000) begin
         n++;
         if (n == 2)    chk_eq({tag, "_nc_init"}, if3.init_done, 1);
         if (n == 8000) chk_eq({tag, "_mid_init"}, if4.init_done, 0);
         @(negedge clk);
      end
      chk_eq({tag, "_cycles"}, n, 16384);
      chk_eq({tag, "_init_done"}, if4.init_done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #23;
      chk_eq("rst_ready4", o_ready, 0);
      chk_eq("rst_rspv4", o_rsp_valid, 0);
      chk_eq("rst_rdata4", o_rsp_rdata, 0);
      chk_eq("rst_init4", o_init_done, 0);
      chk_eq("rst_ready3", if3.req_ready, 0);
      chk_eq("rst_init3", if3.init_done, 0);
      chk_eq("rst_rdata3", if3.rsp_rdata, 0);

      // 1: clear sequence, then cleared words read back as zero
      @(negedge clk); rst_n = 1'b1;
      count_clear("t1_clear");
      @(posedge clk); #1;
      rd(16'h0000); rd(16'h7FFF); rd(16'hFFFF);
      expect_rsp("t1_r0000", 16'h0000);
      expect_rsp("t1_r7fff", 16'h0000);
      expect_rsp("t1_rffff", 16'h0000);

      // 2: read right after write
      wr(16'h0010, 16'hA5C3, 2'b11);
      rd(16'h0010);
      expect_rsp("t2_raw", 16'hA5C3);

      // 3: one word per bank, back-to-back reads in reverse order
      wr(16'h0001, 16'h1111, 2'b11);
      wr(16'h4001, 16'h2222, 2'b11);
      wr(16'h8001, 16'h3333, 2'b11);
      wr(16'hC001, 16'h4444, 2'b11);
      rd(16'hC001); rd(16'h8001); rd(16'h4001); rd(16'h0001);
      expect_rsp("t3_b3", 16'h4444);
      expect_rsp("t3_b2", 16'h3333);
      expect_rsp("t3_b1", 16'h2222);
      expect_rsp("t3_b0", 16'h1111);

      // 4: byte enables
      wr(16'h0020, 16'hFFFF, 2'b11);
      wr(16'h0020, 16'h00AB, 2'b01);
      wr(16'h0020, 16'h00AB, 2'b00);
      rd(16'h0020);
      expect_rsp("t4_be_lo", 16'hFFAB);
      wr(16'h0021, 16'hFFFF, 2'b11);
      wr(16'h0021, 16'h5A00, 2'b10);
      rd(16'h0021);
      expect_rsp("t4_be_hi", 16'h5AFF);

      // 5: BANKS=3, out-of-range bank 3
      sel = 1;
      wr(16'h0000, 16'h1234, 2'b11);
      wr(16'hC000, 16'hBEEF, 2'b11);
      rd(16'hC000);
      expect_rsp("t5_oor", 16'h0000);
      rd(16'h0000);
      expect_rsp("t5_b0", 16'h1234);
      wr(16'h8005, 16'hCAFE, 2'b11);
      rd(16'h8005);
      expect_rsp("t5_b2", 16'hCAFE);
      wr(16'h8005, 16'h0000, 2'b11);
      chk_eq("t5_hold", o_rsp_rdata, 16'hCAFE);

      // 6: reset one cycle after a read accept
      sel = 0;
      rd(16'h0010);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("t6_no_rsp", rsp_dq.size(), 0);
      chk_eq("t6_rspv", o_rsp_valid, 0);
      chk_eq("t6_ready", o_ready, 0);
      chk_eq("t6_init", o_init_done, 0);
      req_cq.delete();
      @(negedge clk); rst_n = 1'b1;
      count_clear("t6_clear");
      chk_eq("t6_no_rsp2", rsp_dq.size(), 0);
      @(posedge clk); #1;
      rd(16'h0010);
      expect_rsp("t6_r0010", 16'h0000);
      rd(16'hC001);
      expect_rsp("t6_rc001", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
